alu_button_debouncer: RTL

//   Upstream input stage of the ALU board top level. Conditions the three raw push buttons
//   (load A, load B, load operator) before the operand/operator capture registers use them.
//   Per button: metastability synchronizer, debounce FSM and clean level output.

---
 rtl/alu_button_debouncer_pkg.sv | 47 ++++
 rtl/alu_button_debouncer_debounce_channel.sv | 108 ++++++++++
 rtl/alu_button_debouncer.sv | 68 ++++++
 3 files changed

// File: rtl/alu_button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// alu_button_debouncer_pkg
//   Shared ALU board definitions for the button input stage:
//     - default number of button channels
//     - button index constants (bit position in the button vectors)
//     - debounce FSM state encoding (2 bits)
//     - defaults for synchroniser depth, debounce length and counter width
//   Imported by the top level and by the per-channel debouncer.
// -----------------------------------------------------------------------------
package alu_button_debouncer_pkg;

    // Number of push buttons on the board (btnL, btnC, btnR).
    localparam int N_BOTON_DEF = 3;

    // Bit position of each button in i_btn / o_btn_level / o_btn_pulse.
    // The strobe arbiter serves the lowest index first, so these positions
    // also fix the service order for simultaneous presses: L, then C, then R.
    localparam int BTN_L = 0;
    localparam int BTN_C = 1;
    localparam int BTN_R = 2;

    // Board defaults: 2-flop synchroniser, 10 ms qualification at 100 MHz.
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int NB_COUNT_DEF        = 20;

    // Debounce FSM states.
    //   IDLE_LOW  : settled released, waiting for the first high sample
    //   WAIT_HIGH : qualifying a press
    //   IDLE_HIGH : settled pressed, waiting for the first low sample
    //   WAIT_LOW  : qualifying a release
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } deb_state_t;

    // Counter value at which the last required stable sample arrives.
    // The sample that moves the FSM out of an IDLE state is the first stable
    // sample, and the counter is cleared on that entry, so the WAIT state sees
    // samples 2..N with counter values 0..N-2.
    function automatic int last_count(input int debounce_cycles);
        return debounce_cycles - 2;
    endfunction

endpackage : alu_button_debouncer_pkg

// File: rtl/alu_button_debouncer_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: metastability synchroniser, stability counter and the
//   debounce FSM that produces a clean, registered button level.
//
//   Ports
//     clk          in   1   system clock, rising edge
//     i_rst_n      in   1   asynchronous, active-low reset
//     i_btn        in   1   raw asynchronous button input, active high
//     o_level      out  1   debounced level (registered)
//     o_press_evt  out  1   high for the single cycle in which the press
//                           qualifies; the owner registers it, so the event
//                           becomes visible together with the level rising
//
//   Timing: a raw input stable from sampling edge k changes o_level after
//   edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
// -----------------------------------------------------------------------------
module debounce_channel
    import alu_button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NB_COUNT        = NB_COUNT_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press_evt
);

    localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(last_count(DEBOUNCE_CYCLES));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state;
    logic [NB_COUNT-1:0]    cnt;
    logic                   cnt_done;

    // Synchroniser: i_btn enters at bit 0, the settled copy leaves at the top.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign cnt_done = (cnt == CNT_LAST);

    // Debounce FSM. Any sample opposite to the target sends the FSM back to
    // its IDLE state, so qualification restarts from zero on the next
    // matching sample. The counter is compared before it is incremented and
    // cleared on every WAIT entry, so it never wraps.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                    end else if (cnt_done) begin
                        state   <= IDLE_HIGH;
                        o_level <= 1'b1;
                    end else begin
                        cnt <= cnt + NB_COUNT'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                    end else if (cnt_done) begin
                        state   <= IDLE_LOW;
                        o_level <= 1'b0;
                    end else begin
                        cnt <= cnt + NB_COUNT'(1);
                    end
                end
                default: begin
                    state   <= IDLE_LOW;
                    cnt     <= '0;
                    o_level <= 1'b0;
                end
            endcase
        end
    end

    // Press qualifies on exactly the edge that raises o_level; releases
    // never produce an event.
    assign o_press_evt = (state == WAIT_HIGH) && s && cnt_done;

endmodule : debounce_channel

// File: rtl/alu_button_debouncer.sv
// -----------------------------------------------------------------------------
// alu_button_debouncer
//   Input stage of the ALU board top level. Conditions the raw push buttons
//   (load A, load B, load operator) before the operand/operator capture
//   registers use them. Each button gets its own debounce_channel; qualified
//   presses are queued in a pending register and released one at a time as
//   single-cycle, one-hot load strobes, lowest index first (L, C, R).
//
//   Ports
//     clk          in   1        system clock, rising edge
//     i_rst_n      in   1        asynchronous, active-low reset
//     i_btn        in   N_BOTON  raw asynchronous buttons, active high
//     o_btn_level  out  N_BOTON  debounced button levels
//     o_btn_pulse  out  N_BOTON  one-hot (or zero) single-cycle press strobe
//
//   A strobe appears one cycle after the corresponding level rises at the
//   earliest; a held button strobes exactly once.
// -----------------------------------------------------------------------------
module alu_button_debouncer
    import alu_button_debouncer_pkg::*;
#(
    parameter int N_BOTON         = N_BOTON_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NB_COUNT        = NB_COUNT_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [N_BOTON-1:0] i_btn,
    output logic [N_BOTON-1:0] o_btn_level,
    output logic [N_BOTON-1:0] o_btn_pulse
);

    logic [N_BOTON-1:0] press_evt;
    logic [N_BOTON-1:0] pending;
    logic [N_BOTON-1:0] grant;

    for (genvar i = 0; i < N_BOTON; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .NB_COUNT        (NB_COUNT)
        ) u_chan (
            .clk         (clk),
            .i_rst_n     (i_rst_n),
            .i_btn       (i_btn[i]),
            .o_level     (o_btn_level[i]),
            .o_press_evt (press_evt[i])
        );
    end

    // Lowest set bit of pending: x & -x isolates it without a priority chain.
    assign grant = pending & (-pending);

    // Pending queue and strobe register. A press qualifying in the same
    // cycle its bit is being granted keeps the bit set, so that press is not
    // lost.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending     <= '0;
            o_btn_pulse <= '0;
        end else begin
            pending     <= (pending & ~grant) | press_evt;
            o_btn_pulse <= grant;
        end
    end

endmodule : alu_button_debouncer
